// File: rtl/hsid_pkg.sv
// hsid_pkg: shared constants and types for the HSID datapath.
// Holds the bus/sample/accumulator/band-count widths used as parameter
// defaults, plus the state type and constants of the multi-lane MSE engine.
package hsid_pkg;

  localparam int unsigned HSID_WORD_WIDTH     = 32;
  localparam int unsigned HSID_DATA_WIDTH     = 16;
  localparam int unsigned HSID_ACC_WIDTH      = 40;
  localparam int unsigned HSID_BANDS_WIDTH    = 7;

  localparam int unsigned HSID_MSE_LANES      = 2;
  localparam int unsigned HSID_MSE_PIPE_DEPTH = 3;

  typedef enum logic [2:0] {
    HML_IDLE  = 3'd0,
    HML_ACC   = 3'd1,
    HML_DRAIN = 3'd2,
    HML_DIV   = 3'd3,
    HML_DONE  = 3'd4,
    HML_ERROR = 3'd5
  } hsid_mse_lanes_state_t;

endpackage : hsid_pkg

// File: rtl/hsid_div_seq.sv
// hsid_div_seq: sequential restoring divider, one quotient bit per cycle.
// The first quotient bit is produced on the start edge, so the quotient is
// complete DVD_WIDTH-1 cycles after start, with o_done pulsing in that cycle.
// Only compiled when HSID_MSE_DIV_EN is defined.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clear           synchronous abort
//   i_start           load dividend/divisor and begin
//   i_dividend        DVD_WIDTH dividend
//   i_divisor         DVS_WIDTH divisor (non-zero)
//   o_done            one-cycle pulse, quotient valid
//   o_quotient        DVD_WIDTH truncated quotient
`ifdef HSID_MSE_DIV_EN
module hsid_div_seq
  import hsid_pkg::*;
#(
  parameter int unsigned DVD_WIDTH = HSID_ACC_WIDTH,
  parameter int unsigned DVS_WIDTH = HSID_BANDS_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_start,
  input  logic [DVD_WIDTH-1:0] i_dividend,
  input  logic [DVS_WIDTH-1:0] i_divisor,
  output logic                 o_done,
  output logic [DVD_WIDTH-1:0] o_quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_WIDTH + 1);

  logic [DVD_WIDTH-1:0] r_rem;
  logic [DVD_WIDTH-1:0] r_quo;
  logic [DVS_WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic [DVD_WIDTH-1:0] w_rem_in;
  logic [DVD_WIDTH-1:0] w_quo_in;
  logic [DVS_WIDTH-1:0] w_dvs_in;
  logic [DVD_WIDTH:0]   w_shift;
  logic [DVD_WIDTH:0]   w_dvs_ext;
  logic                 w_ge;
  logic [DVD_WIDTH-1:0] w_rem_nxt;
  logic [DVD_WIDTH-1:0] w_quo_nxt;

  // On start the step works directly on the incoming operands.
  assign w_rem_in  = i_start ? '0 : r_rem;
  assign w_quo_in  = i_start ? i_dividend : r_quo;
  assign w_dvs_in  = i_start ? i_divisor : r_dvs;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder never exceeds the divisor, so truncation is safe.
  assign w_shift   = {w_rem_in, w_quo_in[DVD_WIDTH-1]};
  assign w_dvs_ext = (DVD_WIDTH+1)'(w_dvs_in);
  assign w_ge      = (w_shift >= w_dvs_ext);
  assign w_rem_nxt = w_ge ? DVD_WIDTH'(w_shift - w_dvs_ext) : DVD_WIDTH'(w_shift);
  assign w_quo_nxt = {w_quo_in[DVD_WIDTH-2:0], w_ge};

  // Iteration state.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_nxt;
        r_quo  <= w_quo_nxt;
        r_dvs  <= i_divisor;
        r_cnt  <= CNT_W'(DVD_WIDTH - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done     = r_done;
  assign o_quotient = r_quo;

endmodule : hsid_div_seq
`endif

// File: rtl/hsid_mse_lanes.sv
// hsid_mse_lanes: multi-lane MSE engine. Consumes a captured pixel and a
// library pixel LANES bands per beat through a subtract/square/accumulate
// pipeline and reports the sum of squared errors, or its mean over the
// bands when HSID_MSE_DIV_EN is defined (truncating divide).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_clear             synchronous abort to IDLE, flushes everything
//   i_start             begin a comparison (IDLE/DONE only)
//   i_band_count        number of bands, latched on start
//   i_in_valid          beat valid
//   o_in_ready          engine accepts a beat (ACC state)
//   i_in_cap, i_in_lib  LANES packed samples, lane 0 in the LSBs
//   o_busy              high outside IDLE/DONE/ERROR
//   o_done              one-cycle result pulse
//   o_error             high while in ERROR (band_count of zero)
//   o_mse_value         result, held until replaced or cleared
module hsid_mse_lanes
  import hsid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = HSID_WORD_WIDTH,
  parameter int unsigned DATA_WIDTH  = HSID_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH   = HSID_ACC_WIDTH,
  parameter int unsigned BANDS_WIDTH = HSID_BANDS_WIDTH,
  parameter int unsigned LANES       = HSID_MSE_LANES
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_start,
  input  logic [BANDS_WIDTH-1:0]      i_band_count,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] i_in_cap,
  input  logic [LANES*DATA_WIDTH-1:0] i_in_lib,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [ACC_WIDTH-1:0]        o_mse_value
);

  localparam int unsigned LOG2_LANES = $clog2(LANES);
  localparam int unsigned LCNT_W     = $clog2(LANES) + 1;
  localparam int unsigned EXT_W      = BANDS_WIDTH + 3;
  localparam int unsigned SQ_W       = 2 * DATA_WIDTH;
  localparam int unsigned DRAIN_W    = $clog2(HSID_MSE_PIPE_DEPTH);

  // A single sample must fit in a bus word.
  if (WORD_WIDTH < DATA_WIDTH) begin : g_bad_width
    $error("hsid_mse_lanes: WORD_WIDTH smaller than DATA_WIDTH");
  end

  hsid_mse_lanes_state_t r_state;
  hsid_mse_lanes_state_t w_state_next;

  logic                         r_in_ready;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_error;
  logic [ACC_WIDTH-1:0]         r_mse_value;

  logic [BANDS_WIDTH-1:0]       r_beats_left;
  logic [LCNT_W-1:0]            r_last_lanes;
  logic [DRAIN_W-1:0]           r_drain_cnt;
  logic [ACC_WIDTH-1:0]         r_acc;
  logic                         r_s1_vld;
  logic [LANES-1:0][DATA_WIDTH:0] r_s1_diff;
  logic                         r_s2_vld;
  logic [LANES-1:0][SQ_W-1:0]   r_s2_sq;

  logic                         w_in_ready_d;
  logic                         w_busy_d;
  logic                         w_done_d;
  logic                         w_error_d;
  logic                         w_start_acc;
  logic                         w_beat;
  logic [EXT_W-1:0]             w_bc_ext;
  logic [BANDS_WIDTH-1:0]       w_beats;
  logic [LCNT_W-1:0]            w_last_lanes;
  logic [LANES-1:0][DATA_WIDTH:0] w_diff;
  logic [LANES-1:0][SQ_W-1:0]   w_sq;
  logic [ACC_WIDTH-1:0]         w_lane_sum;
  logic                         w_div_done;

  assign w_start_acc = ((r_state == HML_IDLE) || (r_state == HML_DONE)) &&
                       i_start && (i_band_count != '0);
  assign w_beat      = (r_state == HML_ACC) && i_in_valid;

  // Beat count and number of live lanes in the final beat (LANES is a power of two).
  assign w_bc_ext     = EXT_W'(i_band_count);
  assign w_beats      = BANDS_WIDTH'((w_bc_ext + EXT_W'(LANES - 1)) >> LOG2_LANES);
  assign w_last_lanes = LCNT_W'((w_bc_ext - EXT_W'(1)) & EXT_W'(LANES - 1)) + LCNT_W'(1);

  // Per-lane subtract (S1 input) and square of the registered difference (S2 input).
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] w_cap;
    logic [DATA_WIDTH-1:0] w_lib;
    logic                  w_lane_on;
    logic [DATA_WIDTH-1:0] w_mag;

    assign w_cap     = i_in_cap[l*DATA_WIDTH +: DATA_WIDTH];
    assign w_lib     = i_in_lib[l*DATA_WIDTH +: DATA_WIDTH];
    // Lanes past band_count in the final beat contribute nothing.
    assign w_lane_on = (r_beats_left != BANDS_WIDTH'(1)) || (LCNT_W'(l) < r_last_lanes);
    assign w_diff[l] = w_lane_on ? ({1'b0, w_cap} - {1'b0, w_lib}) : '0;
    // |diff| always fits DATA_WIDTH bits, so square the magnitude unsigned.
    assign w_mag     = r_s1_diff[l][DATA_WIDTH] ? DATA_WIDTH'(-r_s1_diff[l])
                                                : DATA_WIDTH'(r_s1_diff[l]);
    assign w_sq[l]   = SQ_W'(w_mag) * SQ_W'(w_mag);
  end

  // S3 adder tree across lanes.
  always_comb begin
    w_lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_sum = w_lane_sum + ACC_WIDTH'(r_s2_sq[l]);
    end
  end

`ifdef HSID_MSE_DIV_EN
  logic [BANDS_WIDTH-1:0] r_band_count;
  logic                   w_div_start;
  logic [ACC_WIDTH-1:0]   w_div_quo;

  assign w_div_start = (r_state == HML_DRAIN) && (w_state_next == HML_DIV);

  hsid_div_seq #(
    .DVD_WIDTH (ACC_WIDTH),
    .DVS_WIDTH (BANDS_WIDTH)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (i_clear),
    .i_start    (w_div_start),
    .i_dividend (r_acc),
    .i_divisor  (r_band_count),
    .o_done     (w_div_done),
    .o_quotient (w_div_quo)
  );
`else
  assign w_div_done = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= HML_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides everything but reset.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = HML_IDLE;
    end else begin
      case (r_state)
        HML_IDLE, HML_DONE: begin
          if (i_start) begin
            w_state_next = (i_band_count == '0) ? HML_ERROR : HML_ACC;
          end
        end
        HML_ACC: begin
          if (w_beat && (r_beats_left == BANDS_WIDTH'(1))) begin
            w_state_next = HML_DRAIN;
          end
        end
        HML_DRAIN: begin
          if (r_drain_cnt == '0) begin
`ifdef HSID_MSE_DIV_EN
            w_state_next = HML_DIV;
`else
            w_state_next = HML_DONE;
`endif
          end
        end
        HML_DIV: begin
          if (w_div_done) begin
            w_state_next = HML_DONE;
          end
        end
        HML_ERROR: w_state_next = HML_ERROR;
        default:   w_state_next = HML_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    w_in_ready_d = 1'b0;
    w_busy_d     = 1'b0;
    w_done_d     = 1'b0;
    w_error_d    = 1'b0;
    w_in_ready_d = (w_state_next == HML_ACC);
    w_busy_d     = !((w_state_next == HML_IDLE) || (w_state_next == HML_DONE) ||
                     (w_state_next == HML_ERROR));
    w_done_d     = (w_state_next == HML_DONE) && (r_state != HML_DONE);
    w_error_d    = (w_state_next == HML_ERROR);
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_error    <= w_error_d;
    end
  end

  // Datapath: beat counting, pipeline stages, accumulator and result.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_beats_left <= '0;
      r_last_lanes <= '0;
      r_drain_cnt  <= '0;
      r_acc        <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_diff    <= '0;
      r_s2_vld     <= 1'b0;
      r_s2_sq      <= '0;
      r_mse_value  <= '0;
`ifdef HSID_MSE_DIV_EN
      r_band_count <= '0;
`endif
    end else begin
      r_s1_vld  <= w_beat;
      r_s1_diff <= w_diff;
      r_s2_vld  <= r_s1_vld;
      r_s2_sq   <= w_sq;
      if (r_s2_vld) begin
        r_acc <= r_acc + w_lane_sum;
      end

      if (w_start_acc) begin
        r_beats_left <= w_beats;
        r_last_lanes <= w_last_lanes;
        r_acc        <= '0;
`ifdef HSID_MSE_DIV_EN
        r_band_count <= i_band_count;
`endif
      end else if (w_beat) begin
        r_beats_left <= r_beats_left - BANDS_WIDTH'(1);
      end

      // Hold DRAIN until S3 has retired the final beat.
      if ((r_state == HML_ACC) && (w_state_next == HML_DRAIN)) begin
        r_drain_cnt <= DRAIN_W'(HSID_MSE_PIPE_DEPTH - 1);
      end else if ((r_state == HML_DRAIN) && (r_drain_cnt != '0)) begin
        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
      end

      if ((r_state == HML_DRAIN) && (w_state_next == HML_DONE)) begin
        r_mse_value <= r_acc;
      end
`ifdef HSID_MSE_DIV_EN
      if ((r_state == HML_DIV) && (w_state_next == HML_DONE)) begin
        r_mse_value <= w_div_quo;
      end
`endif
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_mse_value = r_mse_value;

endmodule : hsid_mse_lanes

// File: tb/tb_hsid_mse_lanes.sv
// Bench for hsid_mse_lanes: one LANES=2 and one LANES=4 instance. Drivers
// push the expected result and completion cycle into a per-instance queue;
// monitors pop and compare whenever done pulses.
module tb_hsid_mse_lanes;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 40;
  localparam int unsigned BW = 7;
`ifdef HSID_MSE_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif
  localparam int LAT = DIV ? (4 + AW) : 4;

  typedef struct {
    logic [AW-1:0] val;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic          start [2];
  logic          clear [2];
  logic          vld   [2];
  logic [BW-1:0] bc    [2];
  logic          rdy   [2];
  logic          busy  [2];
  logic          done  [2];
  logic          err   [2];
  logic [AW-1:0] mse   [2];
  logic [31:0]   cap0, lib0;
  logic [63:0]   cap1, lib1;

  int   capv [128];
  int   libv [128];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e_mon0, e_mon1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsid_mse_lanes #(.LANES(2)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear[0]), .i_start(start[0]),
    .i_band_count(bc[0]), .i_in_valid(vld[0]), .o_in_ready(rdy[0]),
    .i_in_cap(cap0), .i_in_lib(lib0), .o_busy(busy[0]), .o_done(done[0]),
    .o_error(err[0]), .o_mse_value(mse[0])
  );

  hsid_mse_lanes #(.LANES(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_clear(clear[1]), .i_start(start[1]),
    .i_band_count(bc[1]), .i_in_valid(vld[1]), .o_in_ready(rdy[1]),
    .i_in_cap(cap1), .i_in_lib(lib1), .o_busy(busy[1]), .o_done(done[1]),
    .o_error(err[1]), .o_mse_value(mse[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: sum of squared band differences, mean (truncated) when dividing.
  function automatic logic [AW-1:0] model(input int bands);
    longint unsigned s;
    longint          df;
    s = 0;
    for (int i = 0; i < bands; i++) begin
      df = longint'(capv[i]) - longint'(libv[i]);
      s  = s + longint'(df * df);
    end
    if (DIV) s = s / longint'(bands);
    return AW'(s);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  always @(negedge clk) begin
    if (!rst && done[0]) begin
      if (q0.size() == 0) check("d0 unexpected done", 64'(done[0]), 64'd0);
      else begin
        e_mon0 = q0.pop_front();
        check("d0 mse_value", 64'(mse[0]), 64'(e_mon0.val));
        check("d0 done cycle", 64'(cyc), 64'(e_mon0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done[1]) begin
      if (q1.size() == 0) check("d1 unexpected done", 64'(done[1]), 64'd0);
      else begin
        e_mon1 = q1.pop_front();
        check("d1 mse_value", 64'(mse[1]), 64'(e_mon1.val));
        check("d1 done cycle", 64'(cyc), 64'(e_mon1.cyc));
      end
    end
  end

  task automatic drive_beat(input int d, input int b, input int bands, input bit junk_ones);
    int L;
    int band;
    logic [DW-1:0] cv, lv;
    L = (d == 0) ? 2 : 4;
    for (int l = 0; l < L; l++) begin
      band = b * L + l;
      if (band < bands) begin
        cv = DW'(capv[band]);
        lv = DW'(libv[band]);
      end else if (junk_ones) begin
        cv = '1;
        lv = '0;
      end else begin
        cv = DW'($urandom);
        lv = DW'($urandom);
      end
      if (d == 0) begin
        cap0[l*DW +: DW] = cv;
        lib0[l*DW +: DW] = lv;
      end else begin
        cap1[l*DW +: DW] = cv;
        lib1[l*DW +: DW] = lv;
      end
    end
  endtask

  task automatic run_pixel(input int d, input int bands, input bit gaps,
                           input bit busy_start, input bit junk_ones);
    int   L, nb, b, guard;
    bit   tog, v;
    exp_t e;
    logic [AW-1:0] expv;
    L  = (d == 0) ? 2 : 4;
    nb = (bands + L - 1) / L;
    b  = 0;
    guard = 0;
    tog = 1'b1;
    expv = model(bands);
    @(negedge clk);
    start[d] = 1'b1;
    bc[d]    = BW'(bands);
    @(negedge clk);
    start[d] = 1'b0;
    check($sformatf("d%0d in_ready after start", d), 64'(rdy[d]), 64'd1);
    while (b < nb && guard < 1000) begin
      v   = gaps ? tog : 1'b1;
      tog = !tog;
      drive_beat(d, b, bands, junk_ones);
      vld[d]   = v;
      start[d] = busy_start && (b == 1);
      if (v && rdy[d]) begin
        if (b == nb - 1) begin
          e.val = expv;
          e.cyc = cyc + LAT;
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        b++;
      end
      @(negedge clk);
      guard++;
    end
    vld[d]   = 1'b0;
    start[d] = 1'b0;
    check($sformatf("d%0d beats accepted", d), 64'(b), 64'(nb));
    guard = 0;
    while (qsize(d) != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("d%0d result pending", d), 64'(qsize(d)), 64'd0);
    @(negedge clk);
    check($sformatf("d%0d done one cycle", d), 64'(done[d]), 64'd0);
    check($sformatf("d%0d idle after done", d), 64'(busy[d]), 64'd0);
    check($sformatf("d%0d mse held", d), 64'(mse[d]), 64'(expv));
  endtask

  task automatic error_test(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    bc[d]    = '0;
    vld[d]   = 1'b1;
    @(negedge clk);
    bc[d] = BW'(4);
    check($sformatf("d%0d error set", d), 64'(err[d]), 64'd1);
    check($sformatf("d%0d error in_ready", d), 64'(rdy[d]), 64'd0);
    check($sformatf("d%0d error busy", d), 64'(busy[d]), 64'd0);
    @(negedge clk);
    start[d] = 1'b0;
    check($sformatf("d%0d error holds on start", d), 64'(err[d]), 64'd1);
    check($sformatf("d%0d error ready on start", d), 64'(rdy[d]), 64'd0);
    clear[d] = 1'b1;
    @(negedge clk);
    clear[d] = 1'b0;
    vld[d]   = 1'b0;
    check($sformatf("d%0d error cleared", d), 64'(err[d]), 64'd0);
    check($sformatf("d%0d mse after clear", d), 64'(mse[d]), 64'd0);
  endtask

  task automatic clear_test(input int d, input int bands);
    int b, guard;
    b = 0;
    guard = 0;
    for (int i = 0; i < bands; i++) begin
      capv[i] = int'($urandom_range(0, 65535));
      libv[i] = int'($urandom_range(0, 65535));
    end
    @(negedge clk);
    start[d] = 1'b1;
    bc[d]    = BW'(bands);
    @(negedge clk);
    start[d] = 1'b0;
    while (b < 2 && guard < 100) begin
      drive_beat(d, b, bands, 1'b0);
      vld[d] = 1'b1;
      if (rdy[d]) b++;
      @(negedge clk);
      guard++;
    end
    vld[d]   = 1'b0;
    clear[d] = 1'b1;
    @(negedge clk);
    clear[d] = 1'b0;
    check($sformatf("d%0d clear busy", d), 64'(busy[d]), 64'd0);
    check($sformatf("d%0d clear in_ready", d), 64'(rdy[d]), 64'd0);
    check($sformatf("d%0d clear mse", d), 64'(mse[d]), 64'd0);
    repeat (LAT + 4) @(negedge clk);
    run_pixel(d, bands, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_t1();
    capv[0] = 10; capv[1] = 20; capv[2] = 30; capv[3] = 40;
    libv[0] = 7;  libv[1] = 20; libv[2] = 35; libv[3] = 40;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d, bands;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      clear[i] = 1'b0;
      vld[i]   = 1'b0;
      bc[i]    = '0;
    end
    cap0 = '0; lib0 = '0; cap1 = '0; lib1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("d%0d reset in_ready", i), 64'(rdy[i]), 64'd0);
      check($sformatf("d%0d reset busy", i), 64'(busy[i]), 64'd0);
      check($sformatf("d%0d reset done", i), 64'(done[i]), 64'd0);
      check($sformatf("d%0d reset error", i), 64'(err[i]), 64'd0);
      check($sformatf("d%0d reset mse", i), 64'(mse[i]), 64'd0);
    end

    load_t1();
    run_pixel(0, 4, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      capv[i] = 32'hFFFF;
      libv[i] = 0;
    end
    run_pixel(1, 7, 1'b0, 1'b0, 1'b1);

    load_t1();
    run_pixel(0, 4, 1'b1, 1'b1, 1'b0);

    error_test(0);
    error_test(1);
    clear_test(0, 8);
    clear_test(1, 13);

    for (int k = 0; k < 12; k++) begin
      d = k % 2;
      case (k)
        0, 1:    bands = 1;
        2, 3:    bands = 127;
        4:       bands = 2;
        5:       bands = 5;
        default: bands = int'($urandom_range(1, 127));
      endcase
      for (int i = 0; i < bands; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          capv[i] = ($urandom_range(0, 1) == 1) ? 32'hFFFF : 0;
          libv[i] = 32'hFFFF - capv[i];
        end else begin
          capv[i] = int'($urandom_range(0, 65535));
          libv[i] = int'($urandom_range(0, 65535));
        end
      end
      run_pixel(d, bands, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_hsid_mse_lanes
